control_unit: RTL and testbench

//  Hardwired control sequencer for the ezRISC datapath. Steps T0..T7 per instruction: fetch, then execute per IR opcode.

---
 rtl/ezrisc_pkg.sv | 75 +++++++
 rtl/ezrisc_sel_encode.sv | 38 +++
 rtl/control_unit.sv | 193 +++++++++++++++++++
 tb/tb_control_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ezrisc_pkg.sv
// ezRISC control: opcodes, IR field positions, sequencer state encoding.
// MULDIV_EN: when defined, mul/div decode as their own class; else as nop.
package ezrisc_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_RALU, C_UNARY, C_IMM, C_LD,
        C_ST, C_BR, C_JR, C_MULDIV, C_HALT
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return C_RALU;
            OP_NEG, OP_NOT:                 return C_UNARY;
            OP_ADDI, OP_ANDI, OP_ORI,
            OP_LDI:                         return C_IMM;
            OP_LD:                          return C_LD;
            OP_ST:                          return C_ST;
            OP_BR:                          return C_BR;
            OP_JR:                          return C_JR;
`ifdef MULDIV_EN
            OP_MUL, OP_DIV:                 return C_MULDIV;
`endif
            OP_HALT:                        return C_HALT;
            default:                        return C_NOP;
        endcase
    endfunction

    // Immediate forms reuse the register-form ALU codes.
    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ezrisc_sel_encode.sv
// Register select: picks ra/rb/rc and expands it to one-hot load/drive
// strobes, R0 on the MSB.
module ezrisc_sel_encode #(
    parameter int NUM_GPR = 16,
    parameter int RW      = $clog2(NUM_GPR)
) (
    input  logic [RW-1:0]      ra,
    input  logic [RW-1:0]      rb,
    input  logic [RW-1:0]      rc,
    input  logic               gra,
    input  logic               grb,
    input  logic               grc,
    input  logic               r_in,
    input  logic               r_out,
    output logic [NUM_GPR-1:0] gpr_in,
    output logic [NUM_GPR-1:0] gpr_out
);

    localparam logic [NUM_GPR-1:0] TOP = {1'b1, {(NUM_GPR-1){1'b0}}};

    logic [RW-1:0] sel;
    logic          hit;

    always_comb begin
        sel = '0;
        hit = 1'b1;
        unique case (1'b1)
            gra:     sel = ra;
            grb:     sel = rb;
            grc:     sel = rc;
            default: hit = 1'b0;
        endcase
    end

    assign gpr_in  = (hit && r_in)  ? (TOP >> sel) : '0;
    assign gpr_out = (hit && r_out) ? (TOP >> sel) : '0;

endmodule

// File: rtl/control_unit.sv
// ezRISC hardwired control sequencer: fetch T0-T2, execute T3-T7 by opcode.
// MULDIV_EN: enables the mul/div sequence and the hi_in/lo_in/z_high_out strobes.
module control_unit
    import ezrisc_pkg::*;
#(
    parameter int NUM_GPR = 16,
    parameter int OP_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stop,
    input  logic [31:0]        ir,
    input  logic               con_ff,
    output logic [NUM_GPR-1:0] gpr_in,
    output logic [NUM_GPR-1:0] gpr_out,
    output logic               pc_in,
    output logic               pc_out,
    output logic               inc_pc,
    output logic               ir_in,
    output logic               y_in,
    output logic               z_in,
    output logic               z_high_out,
    output logic               z_low_out,
    output logic               mar_in,
    output logic               mdr_in,
    output logic               mdr_out,
    output logic               read,
    output logic               write,
    output logic               c_out,
    output logic               con_in,
    output logic               hi_in,
    output logic               lo_in,
    output logic [OP_W-1:0]    alu_op,
    output logic               run
);

    state_t    state, nxt;
    op_class_t cls;
    logic [4:0] op;
    logic gra, grb, grc, r_in, r_out, last;
    logic unused_ir;

    assign op  = ir[OP_HI:OP_LO];
    assign cls = op_class(op);
    assign unused_ir = ^ir[RC_LO-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        last = 1'b0;
        {pc_in, pc_out, inc_pc, ir_in, y_in, z_in} = '0;
        {z_high_out, z_low_out, mar_in, mdr_in} = '0;
        {mdr_out, read, write, c_out, con_in} = '0;
        {hi_in, lo_in} = '0;
        {gra, grb, grc, r_in, r_out} = '0;
        alu_op = '0;
        run = 1'b1;
        case (state)
            S_IDLE: begin
                run = 1'b0;
                nxt = stop ? S_IDLE : S_T0;
            end
            S_HALT: run = 1'b0;
            S_T0: begin
                {pc_out, mar_in, inc_pc, z_in} = '1;
                nxt = S_T1;
            end
            S_T1: begin
                {z_low_out, pc_in, read, mdr_in} = '1;
                nxt = S_T2;
            end
            S_T2: begin
                {mdr_out, ir_in} = '1;
                if (cls == C_HALT)     nxt = S_HALT;
                else if (cls == C_NOP) last = 1'b1;
                else                   nxt = S_T3;
            end
            S_T3: begin
                nxt = S_T4;
                case (cls)
                    C_RALU, C_IMM, C_LD, C_ST:
                        {grb, r_out, y_in} = '1;
                    C_UNARY: begin
                        {grb, r_out, z_in} = '1;
                        alu_op = op;
                    end
                    C_BR: {gra, r_out, con_in} = '1;
                    C_JR: begin
                        {gra, r_out, pc_in} = '1;
                        last = 1'b1;
                    end
`ifdef MULDIV_EN
                    C_MULDIV: {gra, r_out, y_in} = '1;
`endif
                    default: last = 1'b1;
                endcase
            end
            S_T4: begin
                nxt = S_T5;
                case (cls)
                    C_RALU: begin
                        {grc, r_out, z_in} = '1;
                        alu_op = op;
                    end
                    C_UNARY: begin
                        {z_low_out, gra, r_in} = '1;
                        last = 1'b1;
                    end
                    C_IMM: begin
                        {c_out, z_in} = '1;
                        alu_op = imm_alu(op);
                    end
                    C_LD, C_ST: begin
                        {c_out, z_in} = '1;
                        alu_op = OP_ADD;
                    end
                    C_BR: {pc_out, y_in} = '1;
`ifdef MULDIV_EN
                    C_MULDIV: begin
                        {grb, r_out, z_in} = '1;
                        alu_op = op;
                    end
`endif
                    default: last = 1'b1;
                endcase
            end
            S_T5: begin
                nxt = S_T6;
                case (cls)
                    C_RALU, C_IMM: begin
                        {z_low_out, gra, r_in} = '1;
                        last = 1'b1;
                    end
                    C_LD, C_ST: {z_low_out, mar_in} = '1;
                    C_BR: begin
                        {c_out, z_in} = '1;
                        alu_op = OP_ADD;
                    end
`ifdef MULDIV_EN
                    C_MULDIV: {z_low_out, lo_in} = '1;
`endif
                    default: last = 1'b1;
                endcase
            end
            S_T6: begin
                nxt = S_T7;
                case (cls)
                    C_LD: {read, mdr_in} = '1;
                    C_ST: {gra, r_out, mdr_in} = '1;
                    C_BR: begin
                        if (con_ff) {pc_in, z_low_out} = '1;
                        last = 1'b1;
                    end
`ifdef MULDIV_EN
                    C_MULDIV: begin
                        {z_high_out, hi_in} = '1;
                        last = 1'b1;
                    end
`endif
                    default: last = 1'b1;
                endcase
            end
            S_T7: begin
                last = 1'b1;
                case (cls)
                    C_LD:    {mdr_out, gra, r_in} = '1;
                    C_ST:    write = 1'b1;
                    default: ;
                endcase
            end
            default: nxt = S_IDLE;
        endcase
        if (last) nxt = stop ? S_IDLE : S_T0;
    end

    ezrisc_sel_encode #(.NUM_GPR(NUM_GPR)) u_sel (
        .ra      (ir[RA_HI:RA_LO]),
        .rb      (ir[RB_HI:RB_LO]),
        .rc      (ir[RC_HI:RC_LO]),
        .gra     (gra),
        .grb     (grb),
        .grc     (grc),
        .r_in    (r_in),
        .r_out   (r_out),
        .gpr_in  (gpr_in),
        .gpr_out (gpr_out)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch, per-class execute, stop/halt.
// Build with +define+MULDIV_EN to exercise the mul/div sequence.
module tb_control_unit;

    logic clk = 1'b0;
    logic reset, stop, con_ff;
    logic [31:0] ir;
    logic [15:0] gpr_in, gpr_out;
    logic pc_in, pc_out, inc_pc, ir_in, y_in, z_in;
    logic z_high_out, z_low_out, mar_in, mdr_in, mdr_out;
    logic read, write, c_out, con_in, hi_in, lo_in, run;
    logic [4:0] alu_op;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [17:0] M_PC_IN  = 18'h20000;
    localparam logic [17:0] M_PC_OUT = 18'h10000;
    localparam logic [17:0] M_INC_PC = 18'h08000;
    localparam logic [17:0] M_IR_IN  = 18'h04000;
    localparam logic [17:0] M_Y_IN   = 18'h02000;
    localparam logic [17:0] M_Z_IN   = 18'h01000;
    localparam logic [17:0] M_ZH_OUT = 18'h00800;
    localparam logic [17:0] M_ZL_OUT = 18'h00400;
    localparam logic [17:0] M_MAR_IN = 18'h00200;
    localparam logic [17:0] M_MDR_IN = 18'h00100;
    localparam logic [17:0] M_MDR_OUT= 18'h00080;
    localparam logic [17:0] M_READ   = 18'h00040;
    localparam logic [17:0] M_WRITE  = 18'h00020;
    localparam logic [17:0] M_C_OUT  = 18'h00010;
    localparam logic [17:0] M_CON_IN = 18'h00008;
    localparam logic [17:0] M_HI_IN  = 18'h00004;
    localparam logic [17:0] M_LO_IN  = 18'h00002;
    localparam logic [17:0] M_RUN    = 18'h00001;

    localparam logic [4:0] A_ADD = 5'b00011;
    localparam logic [4:0] A_AND = 5'b01001;

    logic [17:0] strb;
    assign strb = {pc_in, pc_out, inc_pc, ir_in, y_in, z_in,
                   z_high_out, z_low_out, mar_in, mdr_in, mdr_out,
                   read, write, c_out, con_in, hi_in, lo_in, run};

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .stop(stop), .ir(ir),
        .con_ff(con_ff), .gpr_in(gpr_in), .gpr_out(gpr_out),
        .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc),
        .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .z_high_out(z_high_out), .z_low_out(z_low_out),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
        .read(read), .write(write), .c_out(c_out),
        .con_in(con_in), .hi_in(hi_in), .lo_in(lo_in),
        .alu_op(alu_op), .run(run)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [17:0] es,
                        input logic [15:0] ei, input logic [15:0] eo,
                        input logic [4:0] ea);
        chk({tag, ".strb"}, 32'(strb), 32'(es));
        chk({tag, ".gin"}, 32'(gpr_in), 32'(ei));
        chk({tag, ".gout"}, 32'(gpr_out), 32'(eo));
        chk({tag, ".alu"}, 32'(alu_op), 32'(ea));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op,
        input int ra, input int rb, input int rc, input logic [14:0] imm);
        return {op, 4'(ra), 4'(rb), 4'(rc), imm};
    endfunction

    task automatic fetch(input string tag, input logic [31:0] nir);
        tick;
        step({tag, ".T0"}, M_PC_OUT|M_MAR_IN|M_INC_PC|M_Z_IN|M_RUN,
             16'h0, 16'h0, 5'd0);
        ir = nir;
        tick;
        step({tag, ".T1"}, M_ZL_OUT|M_PC_IN|M_READ|M_MDR_IN|M_RUN,
             16'h0, 16'h0, 5'd0);
        tick;
        step({tag, ".T2"}, M_MDR_OUT|M_IR_IN|M_RUN, 16'h0, 16'h0, 5'd0);
    endtask

    initial begin
        reset = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = '0;
        repeat (2) @(posedge clk);
        #1;
        step("rst", 18'h0, 16'h0, 16'h0, 5'd0);
        reset = 1'b0;
        step("idle", 18'h0, 16'h0, 16'h0, 5'd0);

        // Reset in the middle of add R1,R2,R3
        fetch("add", mk_ir(5'b00011, 1, 2, 3, 15'h0));
        tick; step("add.T3", M_Y_IN|M_RUN, 16'h0, 16'h2000, 5'd0);
        tick; step("add.T4", M_Z_IN|M_RUN, 16'h0, 16'h1000, A_ADD);
        #2 reset = 1'b1;
        #1 step("midrst", 18'h0, 16'h0, 16'h0, 5'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step("rel", 18'h0, 16'h0, 16'h0, 5'd0);

        fetch("and", 32'h4A920000);
        tick; step("and.T3", M_Y_IN|M_RUN, 16'h0, 16'h2000, 5'd0);
        tick; step("and.T4", M_Z_IN|M_RUN, 16'h0, 16'h0800, A_AND);
        tick; step("and.T5", M_ZL_OUT|M_RUN, 16'h0400, 16'h0, 5'd0);

        fetch("ld", mk_ir(5'b00000, 1, 2, 0, 15'h65));
        tick; step("ld.T3", M_Y_IN|M_RUN, 16'h0, 16'h2000, 5'd0);
        tick; step("ld.T4", M_C_OUT|M_Z_IN|M_RUN, 16'h0, 16'h0, A_ADD);
        tick; step("ld.T5", M_ZL_OUT|M_MAR_IN|M_RUN, 16'h0, 16'h0, 5'd0);
        tick; step("ld.T6", M_READ|M_MDR_IN|M_RUN, 16'h0, 16'h0, 5'd0);
        tick; step("ld.T7", M_MDR_OUT|M_RUN, 16'h4000, 16'h0, 5'd0);

        fetch("st", mk_ir(5'b00010, 3, 6, 0, 15'h10));
        tick; step("st.T3", M_Y_IN|M_RUN, 16'h0, 16'h0200, 5'd0);
        tick; step("st.T4", M_C_OUT|M_Z_IN|M_RUN, 16'h0, 16'h0, A_ADD);
        tick; step("st.T5", M_ZL_OUT|M_MAR_IN|M_RUN, 16'h0, 16'h0, 5'd0);
        tick; step("st.T6", M_MDR_IN|M_RUN, 16'h0, 16'h1000, 5'd0);
        tick; step("st.T7", M_WRITE|M_RUN, 16'h0, 16'h0, 5'd0);

        for (int k = 0; k < 2; k++) begin
            con_ff = k[0];
            fetch("br", mk_ir(5'b10010, 7, 0, 0, 15'h8));
            tick; step("br.T3", M_CON_IN|M_RUN, 16'h0, 16'h0100, 5'd0);
            tick; step("br.T4", M_PC_OUT|M_Y_IN|M_RUN, 16'h0, 16'h0, 5'd0);
            tick; step("br.T5", M_C_OUT|M_Z_IN|M_RUN, 16'h0, 16'h0, A_ADD);
            tick;
            if (k == 0) step("br.T6n", M_RUN, 16'h0, 16'h0, 5'd0);
            else step("br.T6t", M_PC_IN|M_ZL_OUT|M_RUN, 16'h0, 16'h0, 5'd0);
        end
        con_ff = 1'b0;

        fetch("neg", mk_ir(5'b10000, 4, 9, 0, 15'h0));
        tick; step("neg.T3", M_Z_IN|M_RUN, 16'h0, 16'h0040, 5'b10000);
        tick; step("neg.T4", M_ZL_OUT|M_RUN, 16'h0800, 16'h0, 5'd0);

        fetch("andi", mk_ir(5'b01100, 2, 3, 0, 15'h5));
        tick; step("andi.T3", M_Y_IN|M_RUN, 16'h0, 16'h1000, 5'd0);
        tick; step("andi.T4", M_C_OUT|M_Z_IN|M_RUN, 16'h0, 16'h0, A_AND);
        tick; step("andi.T5", M_ZL_OUT|M_RUN, 16'h2000, 16'h0, 5'd0);

        fetch("jr", mk_ir(5'b10011, 10, 0, 0, 15'h0));
        tick; step("jr.T3", M_PC_IN|M_RUN, 16'h0, 16'h0020, 5'd0);

        fetch("nop", mk_ir(5'b11001, 0, 0, 0, 15'h0));

        // stop raised during T4 pauses after the last step
        fetch("add2", mk_ir(5'b00011, 1, 2, 3, 15'h0));
        tick; step("add2.T3", M_Y_IN|M_RUN, 16'h0, 16'h2000, 5'd0);
        tick; step("add2.T4", M_Z_IN|M_RUN, 16'h0, 16'h1000, A_ADD);
        stop = 1'b1;
        tick; step("add2.T5", M_ZL_OUT|M_RUN, 16'h4000, 16'h0, 5'd0);
        tick; step("stop.idle", 18'h0, 16'h0, 16'h0, 5'd0);
        tick; step("stop.hold", 18'h0, 16'h0, 16'h0, 5'd0);
        stop = 1'b0;

        fetch("halt", mk_ir(5'b11010, 0, 0, 0, 15'h0));
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("halt.strb", 32'(strb), 32'h0);
            stop = i[0];
        end
        chk("halt.gout", 32'(gpr_out), 32'h0);
        stop = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        step("unhalt", 18'h0, 16'h0, 16'h0, 5'd0);

        fetch("mul", mk_ir(5'b01110, 3, 4, 0, 15'h0));
`ifdef MULDIV_EN
        tick; step("mul.T3", M_Y_IN|M_RUN, 16'h0, 16'h1000, 5'd0);
        tick; step("mul.T4", M_Z_IN|M_RUN, 16'h0, 16'h0800, 5'b01110);
        tick; step("mul.T5", M_ZL_OUT|M_LO_IN|M_RUN, 16'h0, 16'h0, 5'd0);
        tick; step("mul.T6", M_ZH_OUT|M_HI_IN|M_RUN, 16'h0, 16'h0, 5'd0);
`endif
        fetch("post", mk_ir(5'b11001, 0, 0, 0, 15'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
